// File: rtl/jmp_pkg.sv
// Shared definitions for the sequential branch unit.
//   - condition code constants
//   - jump mode and FSM state enums
//   - cond_eval(): resolves a condition code against the latched flags
package jmp_pkg;

   localparam logic [3:0] COND_AL  = 4'd0;
   localparam logic [3:0] COND_EQ  = 4'd1;
   localparam logic [3:0] COND_NE  = 4'd2;
   localparam logic [3:0] COND_ULT = 4'd3;
   localparam logic [3:0] COND_ULE = 4'd4;
   localparam logic [3:0] COND_UGT = 4'd5;
   localparam logic [3:0] COND_UGE = 4'd6;
   localparam logic [3:0] COND_SLT = 4'd7;
   localparam logic [3:0] COND_SLE = 4'd8;
   localparam logic [3:0] COND_SGT = 4'd9;
   localparam logic [3:0] COND_SGE = 4'd10;

   typedef enum logic [1:0] {
      MODE_ABS  = 2'd0,
      MODE_REL  = 2'd1,
      MODE_CALL = 2'd2,
      MODE_RET  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

   // Codes 11-15 are reserved and resolve to "not taken".
   function automatic logic cond_eval(input logic [3:0] cond,
                                      input logic       z,
                                      input logic       o,
                                      input logic       c,
                                      input logic       s);
      logic lt;
      logic res;
      lt = s ^ o;
      case (cond)
         COND_AL:  res = 1'b1;
         COND_EQ:  res = z;
         COND_NE:  res = ~z;
         COND_ULT: res = c;
         COND_ULE: res = c | z;
         COND_UGT: res = ~(c | z);
         COND_UGE: res = ~c;
         COND_SLT: res = lt;
         COND_SLE: res = lt | z;
         COND_SGT: res = ~lt & ~z;
         COND_SGE: res = ~lt;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/jmp_ret_stack.sv
// Return-address stack (LIFO), non-wrapping.
//   clk, reset (async, active-low)
//   push/din  : store din on top when not full
//   pop       : discard top entry when not empty
//   dout      : current top entry (0 when empty)
//   full/empty: occupancy flags
module jmp_ret_stack
   import jmp_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(STACK_DEPTH + 1);

   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [PW-1:0]     ptr_q;

   assign full  = (ptr_q == PW'(STACK_DEPTH));
   assign empty = (ptr_q == '0);

   always_comb begin
      dout = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (ptr_q == PW'(i + 1)) dout = mem_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      end else if (push && !full) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (ptr_q == PW'(i)) mem_q[i] <= din;
         end
         ptr_q <= ptr_q + PW'(1);
      end else if (pop && !empty) begin
         ptr_q <= ptr_q - PW'(1);
      end
   end

endmodule

// File: rtl/jmp_seq_unit.sv
// Sequential branch unit: latches a jump request, fetches a little-endian
// multi-byte operand, resolves the condition and issues a done pulse with
// an optional PC load. CALL/RET use the return-address stack.
//   in : clk, reset (async, active-low), start, cond, mode, zin/oin/cin/sin,
//        pcin, databus, data_valid
//   out: busy, done, pc_load, pc_out, err_ovf, err_unf
//
// state | meaning
// IDLE  | waiting for start
// FETCH | collecting operand bytes, one per data_valid cycle
// EXEC  | one-cycle result: done, pc_load/error, stack push/pop
module jmp_seq_unit
   import jmp_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        cond,
   input  logic [1:0]        mode,
   input  logic              zin,
   input  logic              oin,
   input  logic              cin,
   input  logic              sin,
   input  logic [ADDR_W-1:0] pcin,
   input  logic [DATA_W-1:0] databus,
   input  logic              data_valid,
   output logic              busy,
   output logic              done,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_out,
   output logic              err_ovf,
   output logic              err_unf
);

   localparam int NB = ADDR_W / DATA_W;
   localparam int CW = $clog2(NB + 1);

   state_e            state_q, state_d;
   mode_e             mode_q;
   logic [3:0]        cond_q;
   logic              z_q, o_q, c_q, s_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] opnd_q, opnd_d;
   logic [CW-1:0]     cnt_q;

   logic              cond_ok;
   logic              stk_push, stk_pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_dout;

   // New bytes enter at the top and shift down, so the first byte ends up
   // in the least significant position after NB shifts.
   assign opnd_d  = (opnd_q >> DATA_W) | (ADDR_W'(databus) << (ADDR_W - DATA_W));
   assign cond_ok = cond_eval(cond_q, z_q, o_q, c_q, s_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_ABS;
         cond_q  <= '0;
         z_q     <= 1'b0;
         o_q     <= 1'b0;
         c_q     <= 1'b0;
         s_q     <= 1'b0;
         pc_q    <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            mode_q <= mode_e'(mode);
            cond_q <= cond;
            z_q    <= zin;
            o_q    <= oin;
            c_q    <= cin;
            s_q    <= sin;
            pc_q   <= pcin;
            opnd_q <= '0;
            cnt_q  <= CW'(NB - 1);
         end else if (state_q == ST_FETCH && data_valid) begin
            opnd_q <= opnd_d;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = (mode_e'(mode) == MODE_RET) ? ST_EXEC : ST_FETCH;
         end
         ST_FETCH: begin
            if (data_valid && cnt_q == '0) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      pc_load  = 1'b0;
      pc_out   = '0;
      err_ovf  = 1'b0;
      err_unf  = 1'b0;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      if (state_q == ST_EXEC) begin
         done = 1'b1;
         if (cond_ok) begin
            case (mode_q)
               MODE_ABS: begin
                  pc_load = 1'b1;
                  pc_out  = opnd_q;
               end
               MODE_REL: begin
                  pc_load = 1'b1;
                  pc_out  = pc_q + opnd_q;
               end
               MODE_CALL: begin
                  if (stk_full) begin
                     err_ovf = 1'b1;
                  end else begin
                     stk_push = 1'b1;
                     pc_load  = 1'b1;
                     pc_out   = opnd_q;
                  end
               end
               MODE_RET: begin
                  if (stk_empty) begin
                     err_unf = 1'b1;
                  end else begin
                     stk_pop = 1'b1;
                     pc_load = 1'b1;
                     pc_out  = stk_dout;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   jmp_ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_q),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

endmodule

// File: tb/tb_jmp_seq_unit.sv
module tb_jmp_seq_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  cond = '0;
   logic [1:0]  mode = '0;
   logic        zin = 1'b0, oin = 1'b0, cin = 1'b0, sin = 1'b0;
   logic [15:0] pcin = '0;
   logic [7:0]  databus = '0;
   logic        data_valid = 1'b0;
   logic        busy, done, pc_load, err_ovf, err_unf;
   logic [15:0] pc_out;

   typedef struct packed {
      logic        load;
      logic [15:0] pc;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t exp_q[$];
   int   id_q[$];
   int   errors = 0;
   int   checks = 0;
   int   req_id = 0;

   always #5 clk = ~clk;

   jmp_seq_unit #(.DATA_W(8), .ADDR_W(16), .STACK_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cond       (cond),
      .mode       (mode),
      .zin        (zin),
      .oin        (oin),
      .cin        (cin),
      .sin        (sin),
      .pcin       (pcin),
      .databus    (databus),
      .data_valid (data_valid),
      .busy       (busy),
      .done       (done),
      .pc_load    (pc_load),
      .pc_out     (pc_out),
      .err_ovf    (err_ovf),
      .err_unf    (err_unf)
   );

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      int   id;
      if (reset && done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got load=%0b pc=%h ovf=%0b unf=%0b, expected no done",
                     pc_load, pc_out, err_ovf, err_unf);
         end else begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            if ({pc_load, pc_out, err_ovf, err_unf} !== {e.load, e.pc, e.ovf, e.unf}) begin
               errors++;
               $display("FAIL req%0d: got load=%0b pc=%h ovf=%0b unf=%0b, expected load=%0b pc=%h ovf=%0b unf=%0b",
                        id, pc_load, pc_out, err_ovf, err_unf, e.load, e.pc, e.ovf, e.unf);
            end
         end
      end
   end

   task automatic chk_busy(input string name);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s: busy=%0b expected 1", name, busy);
      end
   endtask

   // flags = {z,o,c,s}; opnd bytes are sent low byte first.
   task automatic issue(input logic [1:0] m, input logic [3:0] c, input logic [3:0] f,
                        input logic [15:0] pc, input logic [15:0] opnd, input int gap,
                        input bit poke, input logic el, input logic [15:0] ep,
                        input logic eo, input logic eu);
      exp_t e;
      int   k;
      e.load = el; e.pc = ep; e.ovf = eo; e.unf = eu;
      exp_q.push_back(e);
      id_q.push_back(req_id);
      @(negedge clk);
      start = 1'b1; mode = m; cond = c;
      {zin, oin, cin, sin} = f;
      pcin = pc;
      @(negedge clk);
      start = 1'b0;
      {zin, oin, cin, sin} = 4'b0000;
      pcin = 16'hDEAD;
      chk_busy("busy_after_start");
      if (m != 2'd3) begin
         for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < gap; g++) begin
               if (poke) begin
                  start = 1'b1; mode = 2'd3; cond = 4'd0;
               end
               @(negedge clk);
               start = 1'b0;
               chk_busy("busy_in_gap");
            end
            databus = opnd[8*b +: 8];
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            databus = 8'hXX;
         end
      end
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout_req%0d: done=0 after 20 cycles, expected done=1", req_id);
      end
      @(negedge clk);
      req_id++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, pc_load, pc_out, err_ovf, err_unf} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%0b done=%0b load=%0b pc=%h, expected all 0",
                  busy, done, pc_load, pc_out);
      end
      reset = 1'b1;
      @(negedge clk);

      // ABS / REL
      issue(2'd0, 4'd0, 4'b0000, 16'h0000, 16'h1234, 0, 0, 1, 16'h1234, 0, 0);
      issue(2'd1, 4'd1, 4'b1000, 16'h0010, 16'hFFFE, 0, 0, 1, 16'h000E, 0, 0);
      issue(2'd1, 4'd1, 4'b0000, 16'h0010, 16'hFFFE, 0, 0, 0, 16'h0000, 0, 0);

      // RET with false condition on an empty stack: no error
      issue(2'd3, 4'd1, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

      // CALL x5 into a depth-4 stack
      for (int i = 0; i < 4; i++)
         issue(2'd2, 4'd0, 4'b0000, 16'h0100 + 16'(i), 16'h2000, 0, 0, 1, 16'h2000, 0, 0);
      issue(2'd2, 4'd0, 4'b0000, 16'h0104, 16'h2000, 0, 0, 0, 16'h0000, 1, 0);

      // RET x5
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0103, 0, 0);
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0102, 0, 0);
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0101, 0, 0);
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0100, 0, 0);
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);

      // data_valid gaps with ignored start pulses
      issue(2'd0, 4'd0, 4'b0000, 16'h0000, 16'h5678, 3, 1, 1, 16'h5678, 0, 0);

      // signed conditions, s=1 o=0 z=0
      issue(2'd0, 4'd7,  4'b0001, 16'h0, 16'hABCD, 0, 0, 1, 16'hABCD, 0, 0);
      issue(2'd0, 4'd8,  4'b0001, 16'h0, 16'hABCD, 0, 0, 1, 16'hABCD, 0, 0);
      issue(2'd0, 4'd9,  4'b0001, 16'h0, 16'hABCD, 0, 0, 0, 16'h0000, 0, 0);
      issue(2'd0, 4'd10, 4'b0001, 16'h0, 16'hABCD, 0, 0, 0, 16'h0000, 0, 0);
      // s=1 o=1 z=0
      issue(2'd0, 4'd9,  4'b0101, 16'h0, 16'h0F0F, 0, 0, 1, 16'h0F0F, 0, 0);
      // reserved codes, with every flag set and with none
      for (int c = 11; c < 16; c++) begin
         issue(2'd0, 4'(c), 4'b1111, 16'h0, 16'h1111, 0, 0, 0, 16'h0000, 0, 0);
         issue(2'd0, 4'(c), 4'b0000, 16'h0, 16'h1111, 0, 0, 0, 16'h0000, 0, 0);
      end

      // reset mid-operation, with one entry left on the stack beforehand
      issue(2'd2, 4'd0, 4'b0000, 16'h0300, 16'h4000, 0, 0, 1, 16'h4000, 0, 0);
      @(negedge clk);
      start = 1'b1; mode = 2'd0; cond = 4'd0;
      @(negedge clk);
      start = 1'b0;
      databus = 8'h11; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, pc_load, pc_out, err_ovf, err_unf} !== 21'd0) begin
         errors++;
         $display("FAIL reset_abort: got busy=%0b done=%0b load=%0b pc=%h, expected all 0",
                  busy, done, pc_load, pc_out);
      end
      @(negedge clk);
      reset = 1'b1;
      issue(2'd3, 4'd0, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      issue(2'd0, 4'd0, 4'b0000, 16'h0000, 16'h2211, 0, 0, 1, 16'h2211, 0, 0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
